// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised input, mid-bit sampling on an oversample strobe.
// Optional even-parity frame support via `define UART_RX_PARITY_EN.
module uart_rx #(
    parameter int DataWidth  = 8,
    parameter int Oversample = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 baud_tick_i,
    input  logic                 rxd_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 dv_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 busy_o
);
    localparam int TW = $clog2(Oversample);
    localparam int BW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
    localparam logic [TW-1:0] TickLast = TW'(Oversample - 1);
    localparam logic [TW-1:0] TickMid  = TW'(Oversample / 2 - 1);
    localparam logic [BW-1:0] BitLast  = BW'(DataWidth - 1);

    typedef enum logic [2:0] {
        Idle,
        StartBit,
        DataBits,
        ParityBit,
        StopBit
    } state_e;

    state_e                 state_q, state_d;
    logic                   sync1_q, sync2_q, prev_q;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DataWidth-1:0]   shift_q, shift_d;
    logic [DataWidth-1:0]   data_q, data_d;
    logic                   dv_q, dv_d;
    logic                   frame_err_q, frame_err_d;
    logic                   par_err_q, par_err_d;
    logic                   par_bad_q, par_bad_d;
    logic                   rxs;
    logic                   tick_last;

    assign rxs       = sync2_q;
    assign tick_last = (tick_cnt_q == TickLast);

    // NOTE: state registers use non-blocking assignments; all next-state logic lives in always_comb.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= Idle;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            dv_q        <= 1'b0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
            par_bad_q   <= 1'b0;
        end else begin
            sync1_q     <= rxd_i;
            sync2_q     <= sync1_q;
            if (baud_tick_i) prev_q <= rxs;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            dv_q        <= dv_d;
            frame_err_q <= frame_err_d;
            par_err_q   <= par_err_d;
            par_bad_q   <= par_bad_d;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        dv_d        = 1'b0;
        frame_err_d = 1'b0;
        par_err_d   = 1'b0;
        par_bad_d   = par_bad_q;
        if (baud_tick_i) begin
            unique case (state_q)
                Idle: begin
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    par_bad_d  = 1'b0;
                    if (prev_q && !rxs) state_d = StartBit;
                end
                StartBit: begin
                    if (tick_cnt_q == TickMid) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rxs ? Idle : DataBits;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                DataBits: begin
                    if (tick_last) begin
                        tick_cnt_d = '0;
                        shift_d    = {rxs, shift_q[DataWidth-1:1]};
                        if (bit_cnt_q == BitLast) begin
                            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d   = ParityBit;
`else
                            state_d   = StopBit;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                ParityBit: begin
                    if (tick_last) begin
                        tick_cnt_d = '0;
                        par_bad_d  = (^shift_q) ^ rxs;
                        state_d    = StopBit;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                StopBit: begin
                    if (tick_last) begin
                        tick_cnt_d = '0;
                        state_d    = Idle;
                        // Frame error wins over parity error; either one suppresses dv.
                        if (!rxs) begin
                            frame_err_d = 1'b1;
                        end else if (par_bad_q) begin
                            par_err_d = 1'b1;
                        end else begin
                            data_d = shift_q;
                            dv_d   = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                default: state_d = Idle;
            endcase
        end
    end

    assign data_o      = data_q;
    assign dv_o        = dv_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = (state_q != Idle);
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = par_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames plus random frames against a frame-level model.
// Honours `define UART_RX_PARITY_EN to insert a parity bit in every transmitted frame.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] data_o;
    logic       dv_o, frame_err_o, parity_err_o, busy_o;

    int checks = 0;
    int errors = 0;
    int dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, excl_viol = 0;
    logic [7:0] dv_data[$];
    logic [7:0] exp_data = 8'h00;

    uart_rx #(.DataWidth(8), .Oversample(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .baud_tick_i  (baud_tick),
        .rxd_i        (rxd),
        .data_o       (data_o),
        .dv_o         (dv_o),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    initial begin : tick_gen
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            baud_tick = (c == 3);
            c = (c + 1) % 4;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (dv_o) begin
                dv_cnt++;
                dv_data.push_back(data_o);
            end
            if (frame_err_o) fe_cnt++;
            if (parity_err_o) pe_cnt++;
            if (dv_o && (frame_err_o || parity_err_o)) excl_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int ticks);
        rxd = v;
        repeat (ticks * 4) @(negedge clk);
    endtask

    // Serial frame: start, 8 data bits LSB first, [even parity, optionally flipped], stop.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) hold(d[i], 16);
`ifdef UART_RX_PARITY_EN
        hold((^d) ^ par_flip, 16);
`endif
        hold(stop, 16);
    endtask

    // Frame-level model: send, then compare pulse counts and held data against expectations.
    task automatic frame_and_check(input string tag, input logic [7:0] d, input logic stop,
                                   input logic par_flip);
        int dv0, fe0, pe0;
        logic good, par_err;
        dv0 = dv_cnt; fe0 = fe_cnt; pe0 = pe_cnt;
`ifdef UART_RX_PARITY_EN
        par_err = par_flip;
`else
        par_err = 1'b0;
`endif
        good = stop && !par_err;
        send_frame(d, stop, par_flip);
        if (good) exp_data = d;
        check({tag, " dv"}, 32'(dv_cnt - dv0), good ? 32'd1 : 32'd0);
        check({tag, " ferr"}, 32'(fe_cnt - fe0), stop ? 32'd0 : 32'd1);
        check({tag, " perr"}, 32'(pe_cnt - pe0), (stop && par_err) ? 32'd1 : 32'd0);
        check({tag, " data"}, 32'(data_o), 32'(exp_data));
        check({tag, " busy"}, 32'(busy_o), 32'd0);
    endtask

    initial begin : main
        int dv0, fe0;
        logic [7:0] rd;
        logic       rs;

        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("reset data", 32'(data_o), 32'h0);
        check("reset dv", 32'(dv_o), 32'h0);
        check("reset ferr", 32'(frame_err_o), 32'h0);
        check("reset perr", 32'(parity_err_o), 32'h0);
        check("reset busy", 32'(busy_o), 32'h0);
        hold(1'b1, 32);

        // Good frame 0xA5.
        frame_and_check("t1 A5", 8'hA5, 1'b1, 1'b0);
        hold(1'b1, 16);

        // False start: low for 6 ticks, then high.
        dv0 = dv_cnt; fe0 = fe_cnt;
        hold(1'b0, 4);
        check("t2 busy during start", 32'(busy_o), 32'd1);
        hold(1'b0, 2);
        hold(1'b1, 24);
        check("t2 busy after false start", 32'(busy_o), 32'd0);
        check("t2 no dv", 32'(dv_cnt - dv0), 32'd0);
        check("t2 no ferr", 32'(fe_cnt - fe0), 32'd0);

        // Bad stop bit, then a break: no retrigger.
        frame_and_check("t3 3C", 8'h3C, 1'b0, 1'b0);
        dv0 = dv_cnt; fe0 = fe_cnt;
        hold(1'b0, 48);
        check("t3 break busy", 32'(busy_o), 32'd0);
        check("t3 break dv", 32'(dv_cnt - dv0), 32'd0);
        check("t3 break ferr", 32'(fe_cnt - fe0), 32'd0);
        hold(1'b1, 32);

        // Back-to-back frames, no idle gap.
        dv_data.delete();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        exp_data = 8'hFF;
        check("t4 dv count", 32'(dv_data.size()), 32'd2);
        if (dv_data.size() == 2) begin
            check("t4 first", 32'(dv_data[0]), 32'h00);
            check("t4 second", 32'(dv_data[1]), 32'hFF);
        end
        check("t4 data held", 32'(data_o), 32'hFF);
        hold(1'b1, 16);

        // Reset mid-frame after three data bits of 0x81.
        dv0 = dv_cnt; fe0 = fe_cnt;
        hold(1'b0, 16);
        hold(1'b1, 16);
        hold(1'b0, 16);
        hold(1'b0, 16);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rxd = 1'b1;
        exp_data = 8'h00;
        check("t5 data reset", 32'(data_o), 32'h0);
        check("t5 busy reset", 32'(busy_o), 32'h0);
        check("t5 dv reset", 32'(dv_o), 32'h0);
        hold(1'b1, 32);
        check("t5 no pulse", 32'(dv_cnt - dv0 + fe_cnt - fe0), 32'd0);
        frame_and_check("t5 5A", 8'h5A, 1'b1, 1'b0);

`ifdef UART_RX_PARITY_EN
        hold(1'b1, 16);
        frame_and_check("t6 par ok", 8'h07, 1'b1, 1'b0);
        hold(1'b1, 16);
        frame_and_check("t6 par bad", 8'h07, 1'b1, 1'b1);
`endif

        // Random frames; a bad stop bit is always followed by idle so the next start edge exists.
        for (int n = 0; n < 8; n++) begin
            rd = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            frame_and_check($sformatf("rand%0d", n), rd, rs, 1'($urandom_range(0, 1)));
            if (!rs || $urandom_range(0, 1) == 1) hold(1'b1, 16);
        end

        check("pulse exclusivity", 32'(excl_viol), 32'd0);
`ifndef UART_RX_PARITY_EN
        check("parity tied low", 32'(pe_cnt), 32'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
